// File: rtl/demux_8_out_3_seq_pkg.sv
// demux_8_out_3_seq_pkg: shared sizes and lane-slice helper for the registered 1-to-8 demux
package demux_8_out_3_seq_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int OCC_W = 4;
  localparam int DEF_WIDTH = 32;
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/demux_8_out_3_seq_lane.sv
// demux_8_out_3_seq_lane: one holding register with valid flag; load wins over ack
module demux_8_out_3_seq_lane #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             will_free
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= data;
      r_valid <= 1'b1;
    end else if (ack) begin
      r_valid <= 1'b0;
    end
  end
  assign q         = r_data;
  assign valid     = r_valid;
  assign will_free = r_valid && ack && !load;
endmodule

// File: rtl/demux_8_out_3_seq.sv
// demux_8_out_3_seq: registered 1-to-8 demux with per-lane valid/ack and occupancy count
// Optional round-robin destination pointer enabled by defining DEMUX_AUTO_SEQ_EN.
module demux_8_out_3_seq
  import demux_8_out_3_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef DEMUX_AUTO_SEQ_EN
  input  logic                   in_auto,
`endif
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ack,
  output logic [OCC_W-1:0]       occ_count,
  output logic                   all_full
);
  logic [SEL_W-1:0] w_dst;
  logic             w_accept;
  logic [LANES-1:0] w_free;
  logic [OCC_W-1:0] w_freed;
  logic [OCC_W-1:0] r_occ;
`ifdef DEMUX_AUTO_SEQ_EN
  logic [SEL_W-1:0] r_ptr;
  assign w_dst = in_auto ? r_ptr : in_sel;
  always_ff @(posedge clock) begin
    if (reset) r_ptr <= '0;
    else if (w_accept && in_auto) r_ptr <= r_ptr + 1'b1;
  end
`else
  assign w_dst = in_sel;
`endif
  // Ack on the destination lane frees it for the same-edge reload.
  assign in_ready = !reset && (!out_valid[w_dst] || out_ack[w_dst]);
  assign w_accept = in_valid && in_ready;
  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      demux_8_out_3_seq_lane #(.WIDTH(WIDTH)) u_lane (
        .clock     (clock),
        .reset     (reset),
        .load      (w_accept && (w_dst == SEL_W'(k))),
        .ack       (out_ack[k]),
        .data      (in_data),
        .q         (out_data[lane_lo(k, WIDTH) +: WIDTH]),
        .valid     (out_valid[k]),
        .will_free (w_free[k])
      );
    end
  endgenerate
  always_comb begin
    w_freed = '0;
    for (int i = 0; i < LANES; i++) w_freed = w_freed + OCC_W'(w_free[i]);
  end
  always_ff @(posedge clock) begin
    if (reset) r_occ <= '0;
    else r_occ <= r_occ + OCC_W'(w_accept && !out_valid[w_dst]) - w_freed;
  end
  assign occ_count = r_occ;
  assign all_full  = r_occ == OCC_W'(LANES);
endmodule

// File: tb/tb_demux_8_out_3_seq.sv
// tb_demux_8_out_3_seq: directed self-checking bench for demux_8_out_3_seq
module tb_demux_8_out_3_seq;
  localparam int W = 32;
  logic           clock = 1'b0;
  logic           reset;
  logic [W-1:0]   in_data;
  logic [2:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] out_data;
  logic [7:0]     out_valid;
  logic [7:0]     out_ack;
  logic [3:0]     occ_count;
  logic           all_full;
`ifdef DEMUX_AUTO_SEQ_EN
  logic           in_auto = 1'b0;
`endif
  int checks = 0;
  int failures = 0;

  demux_8_out_3_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef DEMUX_AUTO_SEQ_EN
    .in_auto   (in_auto),
`endif
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .occ_count (occ_count),
    .all_full  (all_full)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [8*W-1:0] got, input logic [8*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] lane(input int k);
    return out_data[k*W +: W];
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_sel = 3'd3; in_data = 32'hFFFF_FFFF; out_ack = '0;
    step(); step();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_occ", occ_count, 0);
    chk("rst_data", out_data, 0);

    reset = 1'b0; in_data = 32'hA5A5_0003; in_sel = 3'd3; in_valid = 1'b1;
    #1 chk("wr3_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("wr3_valid", out_valid, 8'h08);
    chk("wr3_data", lane(3), 32'hA5A5_0003);
    chk("wr3_occ", occ_count, 1);

    in_data = 32'hDEAD_BEEF; in_valid = 1'b1;
    #1 chk("full3_ready", in_ready, 0);
    step(); in_valid = 1'b0;
    chk("full3_data", lane(3), 32'hA5A5_0003);
    chk("full3_valid", out_valid, 8'h08);

    in_data = 32'h0000_1234; in_valid = 1'b1; out_ack = 8'h08;
    #1 chk("reuse_ready", in_ready, 1);
    step(); in_valid = 1'b0; out_ack = '0;
    chk("reuse_valid", out_valid, 8'h08);
    chk("reuse_data", lane(3), 32'h0000_1234);
    chk("reuse_occ", occ_count, 1);

    for (int k = 0; k < 8; k++) begin
      if (k != 3) begin
        in_sel = 3'(k); in_data = 32'h100 + 32'(k); in_valid = 1'b1;
        step();
      end
    end
    in_valid = 1'b0;
    chk("fill_occ", occ_count, 8);
    chk("fill_full", all_full, 1);
    chk("fill_valid", out_valid, 8'hFF);
    chk("fill_lane6", lane(6), 32'h106);
    in_sel = 3'd6; in_valid = 1'b1;
    #1 chk("fill_refuse", in_ready, 0);
    step(); in_valid = 1'b0;
    chk("fill_refuse_data", lane(6), 32'h106);

    out_ack = 8'h21;
    step(); out_ack = '0;
    chk("ack05_occ", occ_count, 6);
    chk("ack05_valid", out_valid, 8'hDE);
    chk("ack05_full", all_full, 0);
    chk("ack05_keep", lane(0), 32'h100);

    out_ack = 8'h04;
    step();
    chk("ack2_valid", out_valid, 8'hDA);
    chk("ack2_occ", occ_count, 5);
    step(); out_ack = '0;
    chk("ack_empty_valid", out_valid, 8'hDA);
    chk("ack_empty_occ", occ_count, 5);

    in_sel = 3'd0; in_data = 32'h77; in_valid = 1'b1; out_ack = 8'h02;
    step(); in_valid = 1'b0; out_ack = '0;
    chk("mix_valid", out_valid, 8'hD9);
    chk("mix_occ", occ_count, 5);
    chk("mix_data", lane(0), 32'h77);

    in_sel = 3'd2; in_valid = 1'b1; reset = 1'b1;
    #1 chk("midrst_ready", in_ready, 0);
    step(); reset = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_occ", occ_count, 0);
    chk("midrst_data", out_data, 0);

`ifdef DEMUX_AUTO_SEQ_EN
    in_auto = 1'b1; in_sel = 3'd7;
    for (int k = 0; k < 8; k++) begin
      in_data = 32'h200 + 32'(k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("auto_valid", out_valid, 8'hFF);
    chk("auto_lane0", lane(0), 32'h200);
    chk("auto_lane5", lane(5), 32'h205);
    out_ack = 8'h03;
    step(); out_ack = '0;
    for (int k = 8; k < 10; k++) begin
      in_data = 32'h200 + 32'(k); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("auto_wrap0", lane(0), 32'h208);
    chk("auto_wrap1", lane(1), 32'h209);
    chk("auto_wrap_occ", occ_count, 8);
    in_valid = 1'b1;
    #1 chk("auto_ptr2_ready", in_ready, 0);
    in_valid = 1'b0; out_ack = 8'h04;
    #1 chk("auto_ptr2_ackready", in_ready, 1);
    out_ack = '0; in_auto = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
